// File: rtl/io_port_bank_pkg.sv
// Shared definitions for the I/O port bank: default geometry, a constant
// log2 helper and the channel-slice offset helper used to address packed
// per-channel buses.
package io_port_bank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_CH_DEF   = 2;
    localparam int DEPTH_DEF  = 4;
    localparam int CH_W_DEF   = 3;

    // Smallest r with 2**r >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Low bit of channel ch inside a packed bus of width-wide lanes.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/io_port_bank_fifo.sv
// io_fifo: synchronous first-word-fall-through FIFO. The head word is
// visible on dout whenever the FIFO holds data and dout is forced to zero
// when it is empty. Push into a full FIFO and pop from an empty one are
// ignored here; the parent decides whether that is an error.
module io_fifo
    import io_port_bank_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Full/empty come from the registered count only, so a same-cycle pop
    // never opens room for a push into a full FIFO.
    assign full_s    = (count_r == DEPTH_L);
    assign empty_s   = (count_r == CNT_ZERO);
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: N_CH input and N_CH output channels, each backed by an
// io_fifo. External devices use valid/ready; the CPU reads the input FIFO
// selected by ch_sel through in_data and writes bus_data into the selected
// output FIFO. Misuse by the CPU (write to full, read from empty) is
// recorded in per-channel sticky flags cleared by err_clr.
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [DATA_W-1:0]      bus_data,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic                   out_wr,
    input  logic                   in_rd,
    output logic [DATA_W-1:0]      in_data,
    input  logic [N_CH*DATA_W-1:0] ext_in_data,
    input  logic [N_CH-1:0]        ext_in_valid,
    output logic [N_CH-1:0]        ext_in_ready,
    output logic [N_CH*DATA_W-1:0] ext_out_data,
    output logic [N_CH-1:0]        ext_out_valid,
    input  logic [N_CH-1:0]        ext_out_ready,
    output logic [N_CH-1:0]        in_empty,
    output logic [N_CH-1:0]        out_full,
    output logic [N_CH-1:0]        ovf_err,
    output logic [N_CH-1:0]        udf_err,
    input  logic                   err_clr
);

    localparam int              ADDR_W   = clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ZERO = (ADDR_W + 1)'(0);

    logic                sel_valid_s;
    logic [N_CH-1:0]     sel_hit_s;
    logic [N_CH-1:0]     out_push_s;
    logic [N_CH-1:0]     in_pop_s;
    logic [N_CH-1:0]     in_full_s;
    logic [N_CH-1:0]     in_fifo_empty_s;
    logic [N_CH-1:0]     out_full_s;
    logic [N_CH-1:0]     out_fifo_empty_s;
    logic [N_CH-1:0]     ovf_set_s;
    logic [N_CH-1:0]     udf_set_s;
    logic [N_CH-1:0]     ovf_err_r;
    logic [N_CH-1:0]     udf_err_r;
    logic [DATA_W-1:0]   in_dout_s  [N_CH];
    logic [ADDR_W:0]     in_count_s [N_CH];
    logic [ADDR_W:0]     out_count_s[N_CH];
    logic [DATA_W-1:0]   in_data_s;

    // Out-of-range selects address nothing: no transfer, no flag.
    assign sel_valid_s = ({1'b0, ch_sel} < (CH_W + 1)'(N_CH));

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign sel_hit_s[k]  = sel_valid_s & (ch_sel == CH_W'(k));
        assign out_push_s[k] = out_wr & sel_hit_s[k];
        assign in_pop_s[k]   = in_rd & sel_hit_s[k];

        io_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_in_fifo (
            .clock (clock),
            .clear (clear),
            .push  (ext_in_valid[k]),
            .pop   (in_pop_s[k]),
            .din   (ext_in_data[ch_lsb(k, DATA_W) +: DATA_W]),
            .dout  (in_dout_s[k]),
            .full  (in_full_s[k]),
            .empty (in_fifo_empty_s[k]),
            .count (in_count_s[k])
        );

        io_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_out_fifo (
            .clock (clock),
            .clear (clear),
            .push  (out_push_s[k]),
            .pop   (ext_out_ready[k]),
            .din   (bus_data),
            .dout  (ext_out_data[ch_lsb(k, DATA_W) +: DATA_W]),
            .full  (out_full_s[k]),
            .empty (out_fifo_empty_s[k]),
            .count (out_count_s[k])
        );

        assign ext_in_ready[k]  = ~in_full_s[k];
        assign ext_out_valid[k] = ~out_fifo_empty_s[k];
        assign in_empty[k]      = (in_count_s[k] == CNT_ZERO);
        assign out_full[k]      = (out_count_s[k] == DEPTH_L);
    end

    // Misuse detection uses the same registered full/empty the FIFOs use.
    assign ovf_set_s = out_push_s & out_full_s;
    assign udf_set_s = in_pop_s & in_fifo_empty_s;

    // Head of the selected input FIFO; zero for empty or unselected.
    always_comb begin
        in_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            if (sel_hit_s[k]) begin
                in_data_s = in_dout_s[k];
            end else begin
                in_data_s = in_data_s;
            end
        end
    end

    assign in_data = in_data_s;

    // Sticky error flags; err_clr wins over a same-cycle set.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ovf_err_r <= {N_CH{1'b0}};
            udf_err_r <= {N_CH{1'b0}};
        end else if (err_clr) begin
            ovf_err_r <= {N_CH{1'b0}};
            udf_err_r <= {N_CH{1'b0}};
        end else begin
            ovf_err_r <= ovf_err_r | ovf_set_s;
            udf_err_r <= udf_err_r | udf_set_s;
        end
    end

    assign ovf_err = ovf_err_r;
    assign udf_err = udf_err_r;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank (DATA_W=32, N_CH=2, DEPTH=4, CH_W=3).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// i.e. the expected values describe the state just before the next rising
// edge with the new inputs applied.
module tb_io_port_bank;

    logic        clock;
    logic        clear;
    logic [31:0] bus_data;
    logic [2:0]  ch_sel;
    logic        out_wr;
    logic        in_rd;
    logic [31:0] in_data;
    logic [63:0] ext_in_data;
    logic [1:0]  ext_in_valid;
    logic [1:0]  ext_in_ready;
    logic [63:0] ext_out_data;
    logic [1:0]  ext_out_valid;
    logic [1:0]  ext_out_ready;
    logic [1:0]  in_empty;
    logic [1:0]  out_full;
    logic [1:0]  ovf_err;
    logic [1:0]  udf_err;
    logic        err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    io_port_bank dut (
        .clock         (clock),
        .clear         (clear),
        .bus_data      (bus_data),
        .ch_sel        (ch_sel),
        .out_wr        (out_wr),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_empty      (in_empty),
        .out_full      (out_full),
        .ovf_err       (ovf_err),
        .udf_err       (udf_err),
        .err_clr       (err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  sel;
        logic        wr;
        logic        rd;
        logic [31:0] bus;
        logic [1:0]  iv;
        logic [63:0] idat;
        logic [1:0]  ordy;
        logic        eclr;
        logic [31:0] e_ind;
        logic [1:0]  e_rdy;
        logic [1:0]  e_ov;
        logic [1:0]  e_ie;
        logic [1:0]  e_of;
        logic [1:0]  e_ovf;
        logic [1:0]  e_udf;
        logic [63:0] e_od;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [2:0] sel, input logic wr, input logic rd,
                       input logic [31:0] bus, input logic [1:0] iv, input logic [63:0] idat,
                       input logic [1:0] ordy, input logic eclr,
                       input logic [31:0] e_ind, input logic [1:0] e_rdy, input logic [1:0] e_ov,
                       input logic [1:0] e_ie, input logic [1:0] e_of, input logic [1:0] e_ovf,
                       input logic [1:0] e_udf, input logic [63:0] e_od);
        vec_t v;
        v.sel = sel; v.wr = wr; v.rd = rd; v.bus = bus; v.iv = iv; v.idat = idat;
        v.ordy = ordy; v.eclr = eclr; v.e_ind = e_ind; v.e_rdy = e_rdy; v.e_ov = e_ov;
        v.e_ie = e_ie; v.e_of = e_of; v.e_ovf = e_ovf; v.e_udf = e_udf; v.e_od = e_od;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        bus_data = 32'h0; ch_sel = 3'd0; out_wr = 1'b0; in_rd = 1'b0;
        ext_in_data = 64'h0; ext_in_valid = 2'b00; ext_out_ready = 2'b00; err_clr = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_data"},       64'(in_data),       64'h0);
        chk({tag, " ext_in_ready"},  64'(ext_in_ready),  64'h3);
        chk({tag, " ext_out_valid"}, 64'(ext_out_valid), 64'h0);
        chk({tag, " in_empty"},      64'(in_empty),      64'h3);
        chk({tag, " out_full"},      64'(out_full),      64'h0);
        chk({tag, " ovf_err"},       64'(ovf_err),       64'h0);
        chk({tag, " udf_err"},       64'(udf_err),       64'h0);
        chk({tag, " ext_out_data"},  ext_out_data,       64'h0);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w;
        string tag;

        // sel wr rd bus iv idat ordy eclr | in_data rdy ov ie of ovf udf out_data
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        // input fill on ch1
        add(3'd1,1'b0,1'b0,32'h0, 2'b10,{32'hA1,32'h0}, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b0,32'h0, 2'b10,{32'hA2,32'h0}, 2'b00,1'b0, 32'hA1,2'b11,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b0,32'h0, 2'b10,{32'hA3,32'h0}, 2'b00,1'b0, 32'hA1,2'b11,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b0,32'h0, 2'b10,{32'hA4,32'h0}, 2'b00,1'b0, 32'hA1,2'b11,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b0,32'h0, 2'b10,{32'hA5,32'h0}, 2'b00,1'b0, 32'hA1,2'b01,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        // drain ch1 by CPU reads
        add(3'd1,1'b0,1'b1,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'hA1,2'b01,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b1,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'hA2,2'b11,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b1,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'hA3,2'b11,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b1,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'hA4,2'b11,2'b00,2'b01,2'b00,2'b00,2'b00,64'h0);
        add(3'd1,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        // output overflow on ch0
        add(3'd0,1'b1,1'b0,32'h10,2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        add(3'd0,1'b1,1'b0,32'h11,2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b00,2'b00,2'b00,64'h10);
        add(3'd0,1'b1,1'b0,32'h12,2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b00,2'b00,2'b00,64'h10);
        add(3'd0,1'b1,1'b0,32'h13,2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b00,2'b00,2'b00,64'h10);
        add(3'd0,1'b1,1'b0,32'h14,2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b01,2'b00,2'b00,64'h10);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b01,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b01,2'b01,2'b00,64'h10);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b01,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b00,2'b01,2'b00,64'h11);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b01,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b00,2'b01,2'b00,64'h12);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b01,1'b0, 32'h0, 2'b11,2'b01,2'b11,2'b00,2'b01,2'b00,64'h13);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b01,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b01,2'b00,64'h0);
        // underflow, then clear
        add(3'd0,1'b0,1'b1,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b01,2'b00,64'h0);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b00,1'b1, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b01,2'b01,64'h0);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        // out-of-range select is ignored
        add(3'd5,1'b1,1'b1,32'hDEAD,2'b00,64'h0,2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        // err_clr beats a same-cycle underflow
        add(3'd0,1'b0,1'b1,32'h0, 2'b00,64'h0, 2'b00,1'b1, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);
        add(3'd0,1'b0,1'b0,32'h0, 2'b00,64'h0, 2'b00,1'b0, 32'h0, 2'b11,2'b00,2'b11,2'b00,2'b00,2'b00,64'h0);

        // Reset: hold clear low for 3 cycles, then release
        idle_inputs();
        clear = 1'b0;
        repeat (3) @(negedge clock);
        #1 chk_reset("in_reset");
        @(negedge clock);
        clear = 1'b1;
        #1 chk_reset("after_reset");

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            ch_sel = vq[i].sel; out_wr = vq[i].wr; in_rd = vq[i].rd; bus_data = vq[i].bus;
            ext_in_valid = vq[i].iv; ext_in_data = vq[i].idat;
            ext_out_ready = vq[i].ordy; err_clr = vq[i].eclr;
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " in_data"},       64'(in_data),       64'(vq[i].e_ind));
            chk({tag, " ext_in_ready"},  64'(ext_in_ready),  64'(vq[i].e_rdy));
            chk({tag, " ext_out_valid"}, 64'(ext_out_valid), 64'(vq[i].e_ov));
            chk({tag, " in_empty"},      64'(in_empty),      64'(vq[i].e_ie));
            chk({tag, " out_full"},      64'(out_full),      64'(vq[i].e_of));
            chk({tag, " ovf_err"},       64'(ovf_err),       64'(vq[i].e_ovf));
            chk({tag, " udf_err"},       64'(udf_err),       64'(vq[i].e_udf));
            chk({tag, " ext_out_data"},  ext_out_data,       vq[i].e_od);
        end

        // Streaming through in FIFO ch1: prefill 2, then push+pop for 10 cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            idle_inputs();
            w = 32'h5000_0000 + 32'(i);
            ch_sel = 3'd1; ext_in_valid = 2'b10; ext_in_data = {w, 32'h0};
            exp_q.push_back(w);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            idle_inputs();
            w = 32'h5000_0000 + 32'(i + 2);
            ch_sel = 3'd1; in_rd = 1'b1; ext_in_valid = 2'b10; ext_in_data = {w, 32'h0};
            #1;
            tag = $sformatf("stream%0d", i);
            chk({tag, " in_data"},  64'(in_data),         64'(exp_q.pop_front()));
            chk({tag, " ready1"},   64'(ext_in_ready[1]), 64'h1);
            chk({tag, " empty1"},   64'(in_empty[1]),     64'h0);
            exp_q.push_back(w);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            idle_inputs();
            ch_sel = 3'd1; in_rd = 1'b1;
            #1;
            chk($sformatf("drain%0d in_data", i), 64'(in_data), 64'(exp_q.pop_front()));
        end
        @(negedge clock);
        idle_inputs();
        #1;
        chk("stream_end in_empty", 64'(in_empty), 64'h3);
        chk("stream_end udf_err",  64'(udf_err),  64'h0);

        // Isolation: in ch0 fills up while out ch1 streams CPU writes
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            idle_inputs();
            ext_in_valid = 2'b01; ext_in_data = {32'h0, 32'hC0 + 32'(i)};
            ch_sel = 3'd1; out_wr = 1'b1; bus_data = 32'hB0 + 32'(i); ext_out_ready = 2'b10;
            #1;
            tag = $sformatf("iso%0d", i);
            chk({tag, " ready0"},  64'(ext_in_ready[0]),  (i < 4) ? 64'h1 : 64'h0);
            chk({tag, " valid1"},  64'(ext_out_valid[1]), (i > 0) ? 64'h1 : 64'h0);
            chk({tag, " data1"},   64'(ext_out_data[63:32]), (i > 0) ? 64'(32'hB0 + 32'(i - 1)) : 64'h0);
            chk({tag, " full1"},   64'(out_full[1]),      64'h0);
        end

        // Asynchronous clear mid-stream, away from any clock edge
        @(negedge clock);
        idle_inputs();
        #1;
        chk("pre_clear in_data", 64'(in_data), 64'hC0);
        #1 clear = 1'b0;
        #1 chk_reset("async_clear");
        @(negedge clock);
        clear = 1'b1;
        #1 chk_reset("post_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
